// File: rtl/dmem_pkg.sv
// Shared types and helpers for the dual-port data memory.
package dmem_pkg;

  // Port B command sequencer states.
  typedef enum logic [1:0] {
    B_IDLE = 2'd0,
    B_EXEC = 2'd1,
    B_RESP = 2'd2
  } b_state_e;

  // Widest word the merge helper handles. Callers size-cast in and out,
  // so one function serves every DATA_W up to this limit.
  localparam int MERGE_W  = 256;
  localparam int MERGE_SW = MERGE_W / 8;

  // Byte-lane merge: lanes with a strobe bit take the new data, others keep the old word.
  function automatic logic [MERGE_W-1:0] merge(input logic [MERGE_W-1:0]  i_old,
                                               input logic [MERGE_W-1:0]  i_new,
                                               input logic [MERGE_SW-1:0] i_strb);
    logic [MERGE_W-1:0] w_res;
    w_res = i_old;
    for (int i = 0; i < MERGE_SW; i++) begin
      if (i_strb[i]) w_res[8*i +: 8] = i_new[8*i +: 8];
    end
    return w_res;
  endfunction

endpackage

// File: rtl/dmem_portb_ctrl.sv
// Port B command sequencer: latches one command, arbitrates against port A
// writes to the same word, and holds the response until it is consumed.
module dmem_portb_ctrl
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 4096
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  // command / response handshake
  input  logic                  i_b_req,
  input  logic                  i_b_we,
  input  logic [ADDR_W-1:0]     i_b_addr,
  input  logic [DATA_W-1:0]     i_b_wdata,
  input  logic [DATA_W/8-1:0]   i_b_wstrb,
  input  logic                  i_b_rready,
  output logic                  o_b_ready,
  output logic [DATA_W-1:0]     o_b_rdata,
  output logic                  o_b_rvalid,
  output logic                  o_b_err,
  output logic [15:0]           o_coll_cnt,
  // port A write activity seen this cycle
  input  logic                  i_a_we,
  input  logic [ADDR_W-1:0]     i_a_addr,
  input  logic [DATA_W/8-1:0]   i_a_wstrb,
  // RAM side: word at the latched address, already merged with any port A write
  input  logic [DATA_W-1:0]     i_base,
  output logic [ADDR_W-1:0]     o_cmd_addr,
  output logic                  o_mem_we,
  output logic [DATA_W-1:0]     o_mem_wdata
);

  localparam int STRB_W = DATA_W / 8;

  b_state_e            r_state;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [STRB_W-1:0]   r_wstrb;
  logic                r_b_ready;
  logic                r_b_rvalid;
  logic                r_b_err;
  logic [DATA_W-1:0]   r_b_rdata;
  logic [15:0]         r_coll_cnt;

  logic                w_inr;
  logic                w_coll;
  logic                w_exec;
  logic [DATA_W-1:0]   w_wword;

  // Out-of-range commands never touch the RAM and never stall.
  assign w_inr   = 32'(r_addr) < DEPTH;
  // Port A wins only when both write overlapping lanes of the same word.
  assign w_coll  = i_a_we && (i_a_addr == r_addr) && r_we && (|(i_a_wstrb & r_wstrb));
  assign w_wword = DATA_W'(merge(MERGE_W'(i_base), MERGE_W'(r_wdata), MERGE_SW'(r_wstrb)));
  assign w_exec  = (r_state == B_EXEC) && w_inr && !w_coll;

  assign o_cmd_addr  = r_addr;
  assign o_mem_we    = w_exec && r_we;
  assign o_mem_wdata = w_wword;
  assign o_b_ready   = r_b_ready;
  assign o_b_rdata   = r_b_rdata;
  assign o_b_rvalid  = r_b_rvalid;
  assign o_b_err     = r_b_err;
  assign o_coll_cnt  = r_coll_cnt;

  // Command FSM with registered handshake outputs and the collision counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= B_IDLE;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_b_ready  <= 1'b0;
      r_b_rvalid <= 1'b0;
      r_b_err    <= 1'b0;
      r_b_rdata  <= '0;
      r_coll_cnt <= '0;
    end else begin
      case (r_state)
        B_IDLE: begin
          r_b_ready <= 1'b1;
          if (r_b_ready && i_b_req) begin
            r_we      <= i_b_we;
            r_addr    <= i_b_addr;
            r_wdata   <= i_b_wdata;
            r_wstrb   <= i_b_wstrb;
            r_b_ready <= 1'b0;
            r_state   <= B_EXEC;
          end
        end
        B_EXEC: begin
          if (!w_inr) begin
            r_b_rdata  <= '0;
            r_b_err    <= 1'b1;
            r_b_rvalid <= 1'b1;
            r_state    <= B_RESP;
          end else if (w_coll) begin
            if (r_coll_cnt != 16'hFFFF) r_coll_cnt <= r_coll_cnt + 16'd1;
          end else begin
            r_b_rdata  <= r_we ? w_wword : i_base;
            r_b_err    <= 1'b0;
            r_b_rvalid <= 1'b1;
            r_state    <= B_RESP;
          end
        end
        B_RESP: begin
          if (i_b_rready) begin
            r_b_rvalid <= 1'b0;
            r_b_err    <= 1'b0;
            r_b_ready  <= 1'b1;
            r_state    <= B_IDLE;
          end
        end
        default: r_state <= B_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/data_memory_dual_port_arb.sv
// True-dual-port data RAM. Port A is the pipeline port (registered read,
// byte strobes); port B is the handshaked bridge port sequenced by dmem_portb_ctrl.
module data_memory_dual_port_arb
  import dmem_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 12,
  parameter int DEPTH   = 4096,
  parameter int RDW_NEW = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_a_we,
  input  logic [ADDR_W-1:0]    i_a_addr,
  input  logic [DATA_W-1:0]    i_a_wdata,
  input  logic [DATA_W/8-1:0]  i_a_wstrb,
  output logic [DATA_W-1:0]    o_a_rdata,
  input  logic                 i_b_req,
  output logic                 o_b_ready,
  input  logic                 i_b_we,
  input  logic [ADDR_W-1:0]    i_b_addr,
  input  logic [DATA_W-1:0]    i_b_wdata,
  input  logic [DATA_W/8-1:0]  i_b_wstrb,
  output logic [DATA_W-1:0]    o_b_rdata,
  output logic                 o_b_rvalid,
  input  logic                 i_b_rready,
  output logic                 o_b_err,
  output logic [15:0]          o_coll_cnt
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_a_rdata;

  logic              w_a_inr;
  logic              w_a_wr;
  logic [IDX_W-1:0]  w_a_idx;
  logic [DATA_W-1:0] w_a_old;
  logic [DATA_W-1:0] w_a_new;

  logic [ADDR_W-1:0] w_cmd_addr;
  logic [IDX_W-1:0]  w_b_idx;
  logic [DATA_W-1:0] w_b_base;
  logic              w_b_wr;
  logic [DATA_W-1:0] w_b_wdata;

  assign w_a_inr = 32'(i_a_addr) < DEPTH;
  assign w_a_wr  = i_a_we && w_a_inr;
  assign w_a_idx = i_a_addr[IDX_W-1:0];
  assign w_a_old = r_mem[w_a_idx];
  assign w_a_new = DATA_W'(merge(MERGE_W'(w_a_old), MERGE_W'(i_a_wdata), MERGE_SW'(i_a_wstrb)));

  // Port B sees port A's merged word when both hit the same address, so
  // disjoint-lane writes both land and a B read returns A's fresh data.
  assign w_b_idx  = w_cmd_addr[IDX_W-1:0];
  assign w_b_base = (w_a_wr && (i_a_addr == w_cmd_addr)) ? w_a_new : r_mem[w_b_idx];

  assign o_a_rdata = r_a_rdata;

  // RAM write ports; B is written last so its word (which already carries A's lanes) wins.
  always_ff @(posedge i_clk) begin
    if (w_a_wr) r_mem[w_a_idx] <= w_a_new;
    if (w_b_wr) r_mem[w_b_idx] <= w_b_wdata;
  end

  // Port A registered read with selectable read-during-write behaviour.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                          r_a_rdata <= '0;
    else if (!w_a_inr)                     r_a_rdata <= '0;
    else if ((RDW_NEW != 0) && i_a_we)     r_a_rdata <= w_a_new;
    else                                   r_a_rdata <= w_a_old;
  end

  dmem_portb_ctrl #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_portb (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_b_req     (i_b_req),
    .i_b_we      (i_b_we),
    .i_b_addr    (i_b_addr),
    .i_b_wdata   (i_b_wdata),
    .i_b_wstrb   (i_b_wstrb),
    .i_b_rready  (i_b_rready),
    .o_b_ready   (o_b_ready),
    .o_b_rdata   (o_b_rdata),
    .o_b_rvalid  (o_b_rvalid),
    .o_b_err     (o_b_err),
    .o_coll_cnt  (o_coll_cnt),
    .i_a_we      (i_a_we),
    .i_a_addr    (i_a_addr),
    .i_a_wstrb   (i_a_wstrb),
    .i_base      (w_b_base),
    .o_cmd_addr  (w_cmd_addr),
    .o_mem_we    (w_b_wr),
    .o_mem_wdata (w_b_wdata)
  );

endmodule

// File: tb/tb_data_memory_dual_port_arb.sv
// Bench for data_memory_dual_port_arb: directed scenarios followed by
// randomized port-B transactions against a word-array reference model.
module tb_data_memory_dual_port_arb;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_we;
  logic [11:0] a_addr;
  logic [31:0] a_wdata;
  logic [3:0]  a_wstrb;
  logic [31:0] a_rdata;
  logic        b_req;
  logic        b_ready;
  logic        b_we;
  logic [11:0] b_addr;
  logic [31:0] b_wdata;
  logic [3:0]  b_wstrb;
  logic [31:0] b_rdata;
  logic        b_rvalid;
  logic        b_rready;
  logic        b_err;
  logic [15:0] coll_cnt;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] mdl [4096];
  logic [15:0] mdl_coll;

  data_memory_dual_port_arb #(
    .DATA_W (32), .ADDR_W (12), .DEPTH (DEPTH), .RDW_NEW (1)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_a_we     (a_we),
    .i_a_addr   (a_addr),
    .i_a_wdata  (a_wdata),
    .i_a_wstrb  (a_wstrb),
    .o_a_rdata  (a_rdata),
    .i_b_req    (b_req),
    .o_b_ready  (b_ready),
    .i_b_we     (b_we),
    .i_b_addr   (b_addr),
    .i_b_wdata  (b_wdata),
    .i_b_wstrb  (b_wstrb),
    .o_b_rdata  (b_rdata),
    .o_b_rvalid (b_rvalid),
    .i_b_rready (b_rready),
    .o_b_err    (b_err),
    .o_coll_cnt (coll_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    for (int i = 0; i < 4; i++) if (s[i]) o[8*i +: 8] = n[8*i +: 8];
    return o;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clock with a port A operation; checks the registered read against the model.
  task automatic a_cyc(input logic we, input logic [11:0] addr, input logic [31:0] data, input logic [3:0] strb);
    logic [31:0] exp;
    a_we = we; a_addr = addr; a_wdata = data; a_wstrb = strb;
    if (int'(addr) < DEPTH) begin
      exp = we ? mrg(mdl[addr], data, strb) : mdl[addr];
      if (we) mdl[addr] = exp;
    end else begin
      exp = '0;
    end
    tick();
    chk("a_rdata", a_rdata, exp);
    a_we = 1'b0;
  endtask

  // Full port B transaction: k stall cycles with an overlapping A write, then a final
  // exec cycle carrying an arbitrary A op, then hold cycles before the response is taken.
  task automatic b_txn(input logic we, input logic [11:0] addr, input logic [31:0] data, input logic [3:0] strb,
                       input int k, input logic [31:0] sdata, input logic [3:0] sstrb,
                       input logic fwe, input logic [11:0] faddr, input logic [31:0] fdata, input logic [3:0] fstrb,
                       input int hold);
    int          w;
    logic [31:0] er;
    logic        ee;
    w = 0;
    while (b_ready !== 1'b1 && w < 8) begin
      a_cyc(1'b0, 12'h000, '0, '0);
      w++;
    end
    chk("b_ready_idle", 32'(b_ready), 32'd1);
    b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = data; b_wstrb = strb;
    a_cyc(1'b0, addr, '0, '0);
    // garbage request while busy must be ignored and must not disturb the latched command
    b_we = 1'($urandom); b_addr = 12'($urandom); b_wdata = $urandom; b_wstrb = 4'($urandom);
    chk("b_ready_busy", 32'(b_ready), 32'd0);
    for (int i = 0; i < k; i++) begin
      a_cyc(1'b1, addr, sdata, sstrb);
      chk("b_rvalid_stall", 32'(b_rvalid), 32'd0);
      if (mdl_coll != 16'hFFFF) mdl_coll++;
    end
    a_cyc(fwe, faddr, fdata, fstrb);
    if (int'(addr) >= DEPTH) begin
      er = '0; ee = 1'b1;
    end else begin
      if (we) mdl[addr] = mrg(mdl[addr], data, strb);
      er = mdl[addr]; ee = 1'b0;
    end
    chk("b_rvalid", 32'(b_rvalid), 32'd1);
    chk("b_rdata", b_rdata, er);
    chk("b_err", 32'(b_err), 32'(ee));
    chk("coll_cnt", 32'(coll_cnt), 32'(mdl_coll));
    for (int i = 0; i < hold; i++) begin
      a_cyc(1'b0, faddr, '0, '0);
      chk("b_rvalid_hold", 32'(b_rvalid), 32'd1);
      chk("b_rdata_hold", b_rdata, er);
      chk("b_err_hold", 32'(b_err), 32'(ee));
      chk("b_ready_resp", 32'(b_ready), 32'd0);
    end
    b_req = 1'b0;
    b_rready = 1'b1;
    a_cyc(1'b0, faddr, '0, '0);
    b_rready = 1'b0;
    chk("b_rvalid_clr", 32'(b_rvalid), 32'd0);
    chk("b_ready_back", 32'(b_ready), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; a_we = 0; a_addr = 0; a_wdata = 0; a_wstrb = 0;
    b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0; b_wstrb = 0; b_rready = 0;
    mdl_coll = '0;
    tick(); tick(); tick();
    chk("rst_a_rdata", a_rdata, 32'd0);
    chk("rst_b_rdata", b_rdata, 32'd0);
    chk("rst_b_rvalid", 32'(b_rvalid), 32'd0);
    chk("rst_b_err", 32'(b_err), 32'd0);
    chk("rst_b_ready", 32'(b_ready), 32'd0);
    chk("rst_coll_cnt", 32'(coll_cnt), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("b_ready_after_rst", 32'(b_ready), 32'd1);

    // clear the working window so every later read has a known value
    for (int i = 0; i < 128; i++) a_cyc(1'b1, 12'(i), 32'd0, 4'hF);

    // 1: port A write then read back
    a_cyc(1'b1, 12'h010, 32'hDEADBEEF, 4'hF);
    a_cyc(1'b0, 12'h010, 32'd0, 4'h0);
    chk("t1_a_read", a_rdata, 32'hDEADBEEF);

    // 2: port B partial write then read
    b_txn(1'b1, 12'h020, 32'h12345678, 4'b0011, 0, 0, 0, 1'b0, 12'h000, 0, 0, 0);
    b_txn(1'b0, 12'h020, 32'h0, 4'hF, 0, 0, 0, 1'b0, 12'h020, 0, 0, 0);
    a_cyc(1'b0, 12'h020, 32'd0, 4'h0);
    chk("t2_word", a_rdata, 32'h00005678);

    // 3: three-cycle collision, port A wins, B lane lands afterwards
    b_txn(1'b1, 12'h030, 32'h000000EE, 4'b0001, 3, 32'h11223344, 4'hF, 1'b0, 12'h030, 0, 0, 0);
    chk("t3_coll_cnt", 32'(coll_cnt), 32'd3);
    a_cyc(1'b0, 12'h030, 32'd0, 4'h0);
    chk("t3_word", a_rdata, 32'h112233EE);

    // 4: disjoint lanes, same cycle, same address
    b_txn(1'b1, 12'h040, 32'h0000CCDD, 4'b0011, 0, 0, 0, 1'b1, 12'h040, 32'hAABB0000, 4'b1100, 0);
    a_cyc(1'b0, 12'h040, 32'd0, 4'h0);
    chk("t4_word", a_rdata, 32'hAABBCCDD);
    chk("t4_coll_cnt", 32'(coll_cnt), 32'd3);

    // 5: out-of-range read with a held response
    b_txn(1'b0, 12'h400, 32'h0, 4'hF, 0, 0, 0, 1'b0, 12'h000, 0, 0, 5);

    // randomized transactions
    for (int t = 0; t < 60; t++) begin
      logic        rwe, fwe;
      logic [11:0] raddr, fa, pa;
      logic [31:0] rd;
      logic [3:0]  rs, ss, fs;
      int          rk, mode;
      rwe   = 1'($urandom);
      raddr = ($urandom_range(0, 7) == 0) ? 12'($urandom_range(1024, 4095)) : 12'($urandom_range(0, 127));
      rd    = $urandom;
      rs    = 4'($urandom_range(1, 15));
      rk    = (rwe && int'(raddr) < DEPTH) ? int'($urandom_range(0, 2)) : 0;
      ss    = rs | 4'($urandom);
      mode  = int'($urandom_range(0, 2));
      fa    = 12'($urandom_range(0, 127));
      fs    = 4'($urandom_range(1, 15));
      fwe   = 1'b0;
      if (mode == 1) begin
        fwe = 1'b1;
        if (fa == raddr) fa = fa ^ 12'h001;
      end else if (mode == 2) begin
        fa = raddr; fwe = 1'b1;
        if (rwe) fs = ~rs;
        if (fs == 4'h0) fwe = 1'b0;
      end
      pa = ($urandom_range(0, 5) == 0) ? 12'($urandom_range(1024, 4095)) : 12'($urandom_range(0, 127));
      a_cyc(1'($urandom), pa, $urandom, 4'($urandom));
      b_txn(rwe, raddr, rd, rs, rk, $urandom, ss, fwe, fa, $urandom, fs, int'($urandom_range(0, 2)));
    end

    // 6: reset while the latched write is executing
    b_req = 1'b1; b_we = 1'b1; b_addr = 12'h050; b_wdata = 32'hCAFEF00D; b_wstrb = 4'hF;
    a_cyc(1'b0, 12'h050, 32'd0, 4'h0);
    b_req = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t6_rvalid", 32'(b_rvalid), 32'd0);
    chk("t6_ready", 32'(b_ready), 32'd0);
    chk("t6_a_rdata", a_rdata, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    mdl_coll = '0;
    tick();
    chk("t6_ready_back", 32'(b_ready), 32'd1);
    chk("t6_coll_cnt", 32'(coll_cnt), 32'd0);
    a_cyc(1'b0, 12'h050, 32'd0, 4'h0);
    chk("t6_word", a_rdata, mdl[12'h050]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
